// File: rtl/lcd_spi_tx_pkg.sv
// Shared definitions for the LCD SPI transmitter: FSM state encoding and the
// layout of a buffered FIFO entry {size, dc, data}.
package lcd_spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    localparam int W_DATA         = 16;
    localparam int W_ENTRY        = 18;
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_DC_BIT   = 16;
    localparam int ENTRY_SIZE_BIT = 17;

    function automatic logic [W_ENTRY-1:0] pack_entry(
        input logic              size,
        input logic              dc,
        input logic [W_DATA-1:0] data
    );
        logic [W_ENTRY-1:0] e;
        e                                = '0;
        e[ENTRY_SIZE_BIT]                = size;
        e[ENTRY_DC_BIT]                  = dc;
        e[ENTRY_DATA_LSB +: W_DATA]      = data;
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: contents are discarded by resetting the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/lcd_spi_tx.sv
// LCD 4-wire serial transmitter: buffers 8/16-bit command/data words and
// shifts them out MSB-first with chip-select and data/command framing.
module lcd_spi_tx
    import lcd_spi_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int W_DIV      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_DIV-1:0]  div,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              in_dc,
    input  logic              in_size,
    output logic              busy,
    output logic              lcd_cs,
    output logic              lcd_dc,
    output logic              lcd_sck,
    output logic              lcd_mosi
);

    // Valid/ready: a word is taken on any clk edge where in_valid && in_ready.
    // in_ready depends only on registered FIFO state, never on in_valid, and
    // the source must hold in_data/in_dc/in_size stable while in_valid waits.

    state_t             state, state_nxt;
    logic [W_DIV-1:0]   cnt, cnt_nxt;
    logic [4:0]         bits, bits_nxt;
    logic [W_DATA-1:0]  shreg, shreg_nxt;
    logic               cs_nxt, dc_nxt, sck_nxt, mosi_nxt;

    logic [W_ENTRY-1:0] rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_push;
    logic               ent_size;
    logic               ent_dc;
    logic [W_DATA-1:0]  ent_data;
    logic [W_DIV-1:0]   h_load;
    logic               cnt_done;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    assign ent_size  = rdata[ENTRY_SIZE_BIT];
    assign ent_dc    = rdata[ENTRY_DC_BIT];
    assign ent_data  = rdata[ENTRY_DATA_LSB +: W_DATA];

    assign h_load    = (div == '0) ? W_DIV'(1) : div;
    assign cnt_done  = (cnt <= W_DIV'(1));

    sync_fifo #(
        .WIDTH (W_ENTRY),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (pack_entry(in_size, in_dc, in_data)),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bits     <= '0;
            shreg    <= '0;
            lcd_cs   <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_sck  <= 1'b0;
            lcd_mosi <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bits     <= bits_nxt;
            shreg    <= shreg_nxt;
            lcd_cs   <= cs_nxt;
            lcd_dc   <= dc_nxt;
            lcd_sck  <= sck_nxt;
            lcd_mosi <= mosi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bits_nxt  = bits;
        shreg_nxt = shreg;
        cs_nxt    = lcd_cs;
        dc_nxt    = lcd_dc;
        sck_nxt   = lcd_sck;
        mosi_nxt  = lcd_mosi;
        fifo_pop  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_LOW;
                    cnt_nxt   = h_load;
                end
            end
            ST_LOW: begin
                if (cnt_done) begin
                    sck_nxt   = 1'b1;
                    state_nxt = ST_HIGH;
                    cnt_nxt   = h_load;
                end else begin
                    cnt_nxt   = cnt - W_DIV'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_done) begin
                    sck_nxt = 1'b0;
                    cnt_nxt = h_load;
                    if (bits > 5'd1) begin
                        bits_nxt  = bits - 5'd1;
                        shreg_nxt = {shreg[W_DATA-2:0], 1'b0};
                        mosi_nxt  = shreg[W_DATA-2];
                        state_nxt = ST_LOW;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_LOW;
                    end else begin
                        state_nxt = ST_TRAIL;
                    end
                end else begin
                    cnt_nxt = cnt - W_DIV'(1);
                end
            end
            ST_TRAIL: begin
                if (cnt_done) begin
                    cs_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt   = cnt - W_DIV'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Word load shared by the IDLE start and the back-to-back chain in HIGH;
        // 8-bit words are left-aligned so the shifter always emits from bit 15.
        if (fifo_pop) begin
            cs_nxt = 1'b0;
            dc_nxt = ent_dc;
            if (ent_size) begin
                shreg_nxt = ent_data;
                mosi_nxt  = ent_data[15];
                bits_nxt  = 5'd16;
            end else begin
                shreg_nxt = {ent_data[7:0], 8'h00};
                mosi_nxt  = ent_data[7];
                bits_nxt  = 5'd8;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: wire monitor on lcd_sck rises, hand-computed
// expected words, frame lengths and rise spacing.
module tb_lcd_spi_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  div;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_dc;
    logic        in_size;
    logic        busy;
    logic        lcd_cs;
    logic        lcd_dc;
    logic        lcd_sck;
    logic        lcd_mosi;

    int tests_run    = 0;
    int tests_failed = 0;

    int   cyc = 0;
    int   cs_low_cycles = 0;
    int   cs_fall_cyc   = -1;
    logic sck_q = 1'b0;
    logic cs_q  = 1'b1;
    int   rise_t[$];
    logic rise_mosi[$];
    logic rise_dc[$];

    int accepted    = 0;
    int first_block = -1;

    lcd_spi_tx #(
        .FIFO_DEPTH (4),
        .W_DIV      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div      (div),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dc    (in_dc),
        .in_size  (in_size),
        .busy     (busy),
        .lcd_cs   (lcd_cs),
        .lcd_dc   (lcd_dc),
        .lcd_sck  (lcd_sck),
        .lcd_mosi (lcd_mosi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Wire monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!lcd_cs) cs_low_cycles++;
        if (!lcd_cs && cs_q && cs_fall_cyc < 0) cs_fall_cyc = cyc;
        if (lcd_sck && !sck_q) begin
            rise_t.push_back(cyc);
            rise_mosi.push_back(lcd_mosi);
            rise_dc.push_back(lcd_dc);
        end
        sck_q = lcd_sck;
        cs_q  = lcd_cs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rise_t.delete();
        rise_mosi.delete();
        rise_dc.delete();
        cs_low_cycles = 0;
        cs_fall_cyc   = -1;
    endtask

    task automatic push_word(input logic [15:0] d, input logic dc, input logic sz);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_dc    = dc;
        in_size  = sz;
        waited   = 0;
        while (!in_ready && waited < 2000) begin
            if (first_block < 0) first_block = accepted;
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 2000) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        accepted++;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while ((busy || !lcd_cs) && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 3000) check(tag, 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] wire_word(input int start, input int n);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (start + i < rise_mosi.size()) w = {w[14:0], rise_mosi[start + i]};
            else w = {w[14:0], 1'b0};
        end
        return w;
    endfunction

    function automatic logic [15:0] dc_log();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < rise_mosi.size(); i++) begin
            if (rise_dc[i]) w = {w[14:0], rise_mosi[i]};
        end
        return w;
    endfunction

    function automatic int count_dc(input int start, input int n);
        int c;
        c = 0;
        for (int i = start; i < start + n && i < rise_dc.size(); i++) begin
            if (rise_dc[i]) c++;
        end
        return c;
    endfunction

    function automatic int bad_gaps(input int exp_gap, input int from);
        int c;
        c = 0;
        for (int i = from + 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i-1] != exp_gap) c++;
        end
        return c;
    endfunction

    task automatic single_word_div1(input logic [7:0] d, input string tag);
        div = d;
        clear_mon();
        push_word(16'hA5C3, 1'b1, 1'b1);
        check({tag, "_busy_after_push"}, 32'(busy), 32'd1);
        check({tag, "_cs_still_high"}, 32'(lcd_cs), 32'd1);
        @(posedge clk); #1;
        check({tag, "_cs_low_after_pop"}, 32'(lcd_cs), 32'd0);
        check({tag, "_first_bit"}, 32'(lcd_mosi), 32'd1);
        wait_idle({tag, "_idle_timeout"});
        check({tag, "_rises"}, 32'(rise_t.size()), 32'd16);
        check({tag, "_word"}, 32'(wire_word(0, 16)), 32'h0000A5C3);
        check({tag, "_cs_low_cycles"}, 32'(cs_low_cycles), 32'd33);
        check({tag, "_bad_gaps"}, 32'(bad_gaps(2, 0)), 32'd0);
        if (rise_t.size() > 0)
            check({tag, "_first_rise_delay"}, 32'(rise_t[0] - cs_fall_cyc), 32'd1);
    endtask

    initial begin
        logic [15:0] words6 [6];
        words6[0] = 16'h0F01; words6[1] = 16'hE2D3; words6[2] = 16'h5A5A;
        words6[3] = 16'h8001; words6[4] = 16'h7FFE; words6[5] = 16'hC3A6;

        rst_n    = 1'b0;
        div      = 8'd1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_dc    = 1'b1;
        in_size  = 1'b1;

        // Reset hold with in_valid asserted.
        repeat (4) @(posedge clk);
        #1;
        check("rst_cs", 32'(lcd_cs), 32'd1);
        check("rst_sck", 32'(lcd_sck), 32'd0);
        check("rst_mosi", 32'(lcd_mosi), 32'd0);
        check("rst_dc", 32'(lcd_dc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_no_rises", 32'(rise_t.size()), 32'd0);

        // div=1 and div=0 must behave identically.
        single_word_div1(8'd1, "div1");
        single_word_div1(8'd0, "div0");

        // div=2: command 0x2A then data 0x1234 in one frame.
        div = 8'd2;
        clear_mon();
        push_word(16'h002A, 1'b0, 1'b0);
        push_word(16'h1234, 1'b1, 1'b1);
        wait_idle("b2b_idle_timeout");
        check("b2b_rises", 32'(rise_t.size()), 32'd24);
        check("b2b_cs_low_cycles", 32'(cs_low_cycles), 32'd98);
        check("b2b_cmd_bits", 32'(wire_word(0, 8)), 32'h0000002A);
        check("b2b_dc_first8", 32'(count_dc(0, 8)), 32'd0);
        check("b2b_dc_next16", 32'(count_dc(8, 16)), 32'd16);
        check("b2b_dc_log", 32'(dc_log()), 32'h00001234);
        check("b2b_bad_gaps", 32'(bad_gaps(4, 0)), 32'd0);

        // div=4: six words pushed continuously into a 4-entry FIFO.
        div = 8'd4;
        clear_mon();
        accepted    = 0;
        first_block = -1;
        for (int i = 0; i < 6; i++) push_word(words6[i], 1'b1, 1'b1);
        wait_idle("fill_idle_timeout");
        check("fill_first_block", 32'(first_block), 32'd5);
        check("fill_rises", 32'(rise_t.size()), 32'd96);
        check("fill_cs_low_cycles", 32'(cs_low_cycles), 32'd772);
        for (int i = 0; i < 6; i++)
            check($sformatf("fill_word%0d", i), 32'(wire_word(16 * i, 16)), 32'(words6[i]));

        // Reset during the 9th bit of a 16-bit word with two words queued.
        div = 8'd2;
        clear_mon();
        push_word(16'hBEEF, 1'b1, 1'b1);
        push_word(16'h1357, 1'b1, 1'b1);
        push_word(16'h2468, 1'b1, 1'b1);
        begin
            int waited;
            waited = 0;
            while (!(rise_t.size() == 8 && lcd_sck == 1'b0) && waited < 500) begin
                @(posedge clk); #1;
                waited++;
            end
            check("mid_rst_reach_bit9", 32'(waited < 500), 32'd1);
        end
        check("mid_rst_bit9_value", 32'(lcd_mosi), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cs", 32'(lcd_cs), 32'd1);
        check("mid_rst_sck", 32'(lcd_sck), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        clear_mon();
        repeat (100) @(posedge clk);
        #1;
        check("mid_rst_no_replay", 32'(rise_t.size()), 32'd0);
        check("mid_rst_cs_idle", 32'(lcd_cs), 32'd1);
        push_word(16'h6C39, 1'b1, 1'b1);
        wait_idle("mid_rst_idle_timeout");
        check("mid_rst_fresh_rises", 32'(rise_t.size()), 32'd16);
        check("mid_rst_fresh_word", 32'(wire_word(0, 16)), 32'h00006C39);

        // div changed from 3 to 1 after the first rise of an 8-bit word.
        div = 8'd3;
        clear_mon();
        push_word(16'h0096, 1'b1, 1'b0);
        begin
            int waited;
            waited = 0;
            while (!lcd_sck && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("divchg_first_rise", 32'(waited < 50), 32'd1);
        end
        div = 8'd1;
        wait_idle("divchg_idle_timeout");
        check("divchg_rises", 32'(rise_t.size()), 32'd8);
        check("divchg_word", 32'(wire_word(0, 8)), 32'h00000096);
        if (rise_t.size() > 1)
            check("divchg_first_gap", 32'(rise_t[1] - rise_t[0]), 32'd4);
        check("divchg_later_gaps", 32'(bad_gaps(2, 1)), 32'd0);
        check("divchg_cs_low_cycles", 32'(cs_low_cycles), 32'd21);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
